// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU-op encodings,
// the NOP instruction word, the reset PC and the default Tnew width.
package id_ex_reg_pkg;

  localparam int          TNEW_W    = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2
  } alu_op_e;

  // Everything held in E apart from Tnew, whose width is a module parameter.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ext_imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  wr_addr;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_we;
    logic        valid;
  } e_stage_t;

  // A later stage supplies the value only if it writes the very register E reads;
  // $0 is hard-wired and never takes a forwarded value.
  function automatic logic fwd_hit(input logic we, input logic [4:0] wr_addr,
                                   input logic [4:0] src_addr);
    return we && (wr_addr == src_addr) && (src_addr != 5'd0);
  endfunction

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// Operand forwarding mux for one E-stage source register (M beats W beats E).
// The bypass network is only built when FWD_PATH_EN is defined.
module fwd_mux
  import id_ex_reg_pkg::*;
(
  input  logic [4:0]  src_addr,
  input  logic [31:0] reg_val,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic        m_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        w_we,
  output logic [31:0] val
);

`ifdef FWD_PATH_EN
  always_comb begin
    val = reg_val;
    if (src_addr == 5'd0) begin
      val = 32'h0;
    end else if (fwd_hit(m_we, m_addr, src_addr)) begin
      val = m_data;
    end else if (fwd_hit(w_we, w_addr, src_addr)) begin
      val = w_data;
    end
  end
`else
  assign val = reg_val;

  // Forwarding sources stay on the interface but are ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{src_addr, m_addr, m_data, m_we, w_addr, w_data, w_we};
`endif

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with NOP insertion on bubble/flush and optional
// operand forwarding from M and W (enabled by defining FWD_PATH_EN).
module id_ex_reg #(
  parameter int          TNEW_W    = id_ex_reg_pkg::TNEW_W,
  parameter logic [31:0] NOP_INSTR = id_ex_reg_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              flush,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic [31:0]       d_rs_val,
  input  logic [31:0]       d_rt_val,
  input  logic [31:0]       d_ext_imm,
  input  logic [4:0]        d_rs_addr,
  input  logic [4:0]        d_rt_addr,
  input  logic [4:0]        d_wr_addr,
  input  logic [1:0]        d_alu_op,
  input  logic              d_alu_src,
  input  logic              d_reg_we,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [4:0]        m_fwd_addr,
  input  logic [31:0]       m_fwd_data,
  input  logic              m_fwd_we,
  input  logic [4:0]        w_fwd_addr,
  input  logic [31:0]       w_fwd_data,
  input  logic              w_fwd_we,
  output logic [31:0]       e_alu_a,
  output logic [31:0]       e_alu_b,
  output logic [31:0]       e_store_data,
  output logic [31:0]       e_pc,
  output logic [31:0]       e_instr,
  output logic [1:0]        e_alu_op,
  output logic [4:0]        e_rs_addr,
  output logic [4:0]        e_rt_addr,
  output logic [4:0]        e_wr_addr,
  output logic              e_reg_we,
  output logic              e_valid,
  output logic [TNEW_W-1:0] e_tnew,
  output logic [TNEW_W-1:0] m_tnew_next
);

  import id_ex_reg_pkg::*;

  // Pipeline control: there is no handshake and E never holds. Every rising
  // edge loads either the D payload or, when bubble or flush is high, a NOP.
  function automatic e_stage_t nop_payload(input logic [31:0] pc);
    e_stage_t p;
    p         = '0;
    p.pc      = pc;
    p.instr   = NOP_INSTR;
    p.alu_op  = ALU_ADD;
    return p;
  endfunction

  e_stage_t          d_payload;
  e_stage_t          e_q;
  logic [TNEW_W-1:0] tnew_q;
  logic [31:0]       fwd_rs;
  logic [31:0]       fwd_rt;

  always_comb begin
    d_payload         = '0;
    d_payload.pc      = d_pc;
    d_payload.instr   = d_instr;
    d_payload.rs_val  = d_rs_val;
    d_payload.rt_val  = d_rt_val;
    d_payload.ext_imm = d_ext_imm;
    d_payload.rs_addr = d_rs_addr;
    d_payload.rt_addr = d_rt_addr;
    d_payload.wr_addr = d_wr_addr;
    d_payload.alu_op  = alu_op_e'(d_alu_op);
    d_payload.alu_src = d_alu_src;
    d_payload.reg_we  = d_reg_we;
    d_payload.valid   = 1'b1;
  end

  // A bubble still records d_pc so a squashed slot can report its PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= nop_payload(RESET_PC);
      tnew_q <= '0;
    end else if (bubble || flush) begin
      e_q    <= nop_payload(d_pc);
      tnew_q <= '0;
    end else begin
      e_q    <= d_payload;
      tnew_q <= d_tnew;
    end
  end

  fwd_mux u_fwd_rs (
    .src_addr (e_q.rs_addr),
    .reg_val  (e_q.rs_val),
    .m_addr   (m_fwd_addr),
    .m_data   (m_fwd_data),
    .m_we     (m_fwd_we),
    .w_addr   (w_fwd_addr),
    .w_data   (w_fwd_data),
    .w_we     (w_fwd_we),
    .val      (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .src_addr (e_q.rt_addr),
    .reg_val  (e_q.rt_val),
    .m_addr   (m_fwd_addr),
    .m_data   (m_fwd_data),
    .m_we     (m_fwd_we),
    .w_addr   (w_fwd_addr),
    .w_data   (w_fwd_data),
    .w_we     (w_fwd_we),
    .val      (fwd_rt)
  );

  assign e_alu_a      = fwd_rs;
  assign e_alu_b      = e_q.alu_src ? e_q.ext_imm : fwd_rt;
  assign e_store_data = fwd_rt;

  assign e_pc      = e_q.pc;
  assign e_instr   = e_q.instr;
  assign e_alu_op  = e_q.alu_op;
  assign e_rs_addr = e_q.rs_addr;
  assign e_rt_addr = e_q.rt_addr;
  assign e_wr_addr = e_q.wr_addr;
  assign e_reg_we  = e_q.reg_we;
  assign e_valid   = e_q.valid;
  assign e_tnew    = tnew_q;

  // Cycles-until-result as seen by M next cycle; a ready result stays ready.
  assign m_tnew_next = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a vector table for single-edge behaviour
// plus hand-written sequences for forwarding priority, $0 and async reset.
module tb_id_ex_reg;

  localparam logic [31:0] EXP_NOP      = 32'h0000_0000;
  localparam logic [31:0] EXP_RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        bubble;
  logic        flush;
  logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_ext_imm;
  logic [4:0]  d_rs_addr, d_rt_addr, d_wr_addr;
  logic [1:0]  d_alu_op;
  logic        d_alu_src, d_reg_we;
  logic [1:0]  d_tnew;
  logic [4:0]  m_fwd_addr, w_fwd_addr;
  logic [31:0] m_fwd_data, w_fwd_data;
  logic        m_fwd_we, w_fwd_we;
  logic [31:0] e_alu_a, e_alu_b, e_store_data, e_pc, e_instr;
  logic [1:0]  e_alu_op;
  logic [4:0]  e_rs_addr, e_rt_addr, e_wr_addr;
  logic        e_reg_we, e_valid;
  logic [1:0]  e_tnew, m_tnew_next;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  id_ex_reg dut (
    .clk(clk), .reset(reset), .bubble(bubble), .flush(flush),
    .d_pc(d_pc), .d_instr(d_instr), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_ext_imm(d_ext_imm), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_wr_addr(d_wr_addr), .d_alu_op(d_alu_op), .d_alu_src(d_alu_src),
    .d_reg_we(d_reg_we), .d_tnew(d_tnew),
    .m_fwd_addr(m_fwd_addr), .m_fwd_data(m_fwd_data), .m_fwd_we(m_fwd_we),
    .w_fwd_addr(w_fwd_addr), .w_fwd_data(w_fwd_data), .w_fwd_we(w_fwd_we),
    .e_alu_a(e_alu_a), .e_alu_b(e_alu_b), .e_store_data(e_store_data),
    .e_pc(e_pc), .e_instr(e_instr), .e_alu_op(e_alu_op),
    .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr), .e_wr_addr(e_wr_addr),
    .e_reg_we(e_reg_we), .e_valid(e_valid), .e_tnew(e_tnew),
    .m_tnew_next(m_tnew_next)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bubble, flush;
    logic [31:0] pc, instr;
    logic [4:0]  rs_addr;
    logic [31:0] rs_val;
    logic [4:0]  rt_addr;
    logic [31:0] rt_val, imm;
    logic [4:0]  wr_addr;
    logic [1:0]  alu_op;
    logic        alu_src, reg_we;
    logic [1:0]  tnew;
    logic [31:0] x_a, x_b, x_store, x_instr;
    logic [4:0]  x_wr;
    logic        x_we;
    logic [1:0]  x_op;
    logic        x_valid;
    logic [1:0]  x_tnew, x_tnext;
  } vec_t;

  vec_t vt[8];

  function automatic vec_t mk(
    logic b, logic f, logic [31:0] pc, logic [31:0] instr,
    logic [4:0] rsa, logic [31:0] rsv, logic [4:0] rta, logic [31:0] rtv,
    logic [31:0] imm, logic [4:0] wr, logic [1:0] op, logic src, logic we,
    logic [1:0] tn,
    logic [31:0] xa, logic [31:0] xb, logic [31:0] xs, logic [31:0] xi,
    logic [4:0] xwr, logic xwe, logic [1:0] xop, logic xv, logic [1:0] xt,
    logic [1:0] xtn);
    vec_t v;
    v.bubble = b; v.flush = f; v.pc = pc; v.instr = instr;
    v.rs_addr = rsa; v.rs_val = rsv; v.rt_addr = rta; v.rt_val = rtv;
    v.imm = imm; v.wr_addr = wr; v.alu_op = op; v.alu_src = src;
    v.reg_we = we; v.tnew = tn;
    v.x_a = xa; v.x_b = xb; v.x_store = xs; v.x_instr = xi; v.x_wr = xwr;
    v.x_we = xwe; v.x_op = xop; v.x_valid = xv; v.x_tnew = xt; v.x_tnext = xtn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_d(input vec_t v);
    bubble = v.bubble; flush = v.flush;
    d_pc = v.pc; d_instr = v.instr;
    d_rs_addr = v.rs_addr; d_rs_val = v.rs_val;
    d_rt_addr = v.rt_addr; d_rt_val = v.rt_val;
    d_ext_imm = v.imm; d_wr_addr = v.wr_addr; d_alu_op = v.alu_op;
    d_alu_src = v.alu_src; d_reg_we = v.reg_we; d_tnew = v.tnew;
  endtask

  task automatic drive_fwd(input logic [4:0] ma, input logic [31:0] md,
                           input logic mwe, input logic [4:0] wa,
                           input logic [31:0] wd, input logic wwe);
    m_fwd_addr = ma; m_fwd_data = md; m_fwd_we = mwe;
    w_fwd_addr = wa; w_fwd_data = wd; w_fwd_we = wwe;
  endtask

  task automatic check_nop(input string tag, input logic [31:0] pc);
    check({tag, ".valid"},  {31'b0, e_valid},  32'h0);
    check({tag, ".instr"},  e_instr,           EXP_NOP);
    check({tag, ".reg_we"}, {31'b0, e_reg_we}, 32'h0);
    check({tag, ".wr"},     {27'b0, e_wr_addr}, 32'h0);
    check({tag, ".tnew"},   {30'b0, e_tnew},   32'h0);
    check({tag, ".pc"},     e_pc,              pc);
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_a;

    //       b  f  pc         instr          rsa rsv           rta rtv           imm           wr op src we tn
    vt[0] = mk(0, 0, 32'h3000, 32'h1111_1111, 1, 32'h5,        2,  32'h7,        32'h44,       3, 0, 0, 1, 1,
               32'h5, 32'h7, 32'h7, 32'h1111_1111, 3, 1, 0, 1, 1, 0);
    vt[1] = mk(0, 0, 32'h3004, 32'h2222_2222, 4, 32'h100,      5,  32'h200,      32'h10,       6, 1, 1, 1, 2,
               32'h100, 32'h10, 32'h200, 32'h2222_2222, 6, 1, 1, 1, 2, 1);
    vt[2] = mk(1, 0, 32'h3008, 32'h3333_3333, 7, 32'h55,       8,  32'h66,       32'h77,       9, 2, 0, 1, 2,
               32'h0, 32'h0, 32'h0, EXP_NOP, 0, 0, 0, 0, 0, 0);
    vt[3] = mk(0, 1, 32'h300c, 32'h4444_4444, 7, 32'h55,       8,  32'h66,       32'h77,       9, 2, 1, 1, 3,
               32'h0, 32'h0, 32'h0, EXP_NOP, 0, 0, 0, 0, 0, 0);
    vt[4] = mk(1, 1, 32'h3010, 32'h4444_4444, 7, 32'h55,       8,  32'h66,       32'h77,       9, 1, 0, 1, 1,
               32'h0, 32'h0, 32'h0, EXP_NOP, 0, 0, 0, 0, 0, 0);
    vt[5] = mk(0, 0, 32'h3014, 32'h5555_5555, 10, 32'hdead_beef, 11, 32'h1234_5678, 32'hffff_fff0, 12, 2, 0, 0, 0,
               32'hdead_beef, 32'h1234_5678, 32'h1234_5678, 32'h5555_5555, 12, 0, 2, 1, 0, 0);
    vt[6] = mk(0, 0, 32'h3018, 32'h6666_6666, 13, 32'h1,       14, 32'h2,        32'h8000_0000, 15, 0, 1, 1, 3,
               32'h1, 32'h8000_0000, 32'h2, 32'h6666_6666, 15, 1, 0, 1, 3, 2);
    vt[7] = mk(1, 0, 32'h301c, 32'h7777_7777, 13, 32'h1,       14, 32'h2,        32'h8000_0000, 15, 0, 1, 1, 3,
               32'h0, 32'h0, 32'h0, EXP_NOP, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive_d(vt[0]);
    bubble = 1'b0; flush = 1'b0;
    drive_fwd(0, 32'h0, 0, 0, 32'h0, 0);
    #2;
    check_nop("reset", EXP_RESET_PC);
    @(negedge clk);
    reset = 1'b0;

    // Table: one edge per vector, forwarding idle.
    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      @(negedge clk);
      drive_d(v);
      exp_q.push_back(v.x_a);
      @(posedge clk);
      #1;
      exp_a = exp_q.pop_front();
      check($sformatf("v%0d.alu_a", i), e_alu_a, exp_a);
      check($sformatf("v%0d.alu_b", i), e_alu_b, v.x_b);
      check($sformatf("v%0d.store", i), e_store_data, v.x_store);
      check($sformatf("v%0d.instr", i), e_instr, v.x_instr);
      check($sformatf("v%0d.pc", i), e_pc, v.pc);
      check($sformatf("v%0d.wr", i), {27'b0, e_wr_addr}, {27'b0, v.x_wr});
      check($sformatf("v%0d.reg_we", i), {31'b0, e_reg_we}, {31'b0, v.x_we});
      check($sformatf("v%0d.alu_op", i), {30'b0, e_alu_op}, {30'b0, v.x_op});
      check($sformatf("v%0d.valid", i), {31'b0, e_valid}, {31'b0, v.x_valid});
      check($sformatf("v%0d.tnew", i), {30'b0, e_tnew}, {30'b0, v.x_tnew});
      check($sformatf("v%0d.tnext", i), {30'b0, m_tnew_next}, {30'b0, v.x_tnext});
      check($sformatf("v%0d.rs_addr", i), {27'b0, e_rs_addr},
            (v.bubble || v.flush) ? 32'h0 : {27'b0, v.rs_addr});
    end

    // M/W priority on r8 (rs), W-only hit on r9 (rt).
    @(negedge clk);
    drive_d(mk(0, 0, 32'h3100, 32'h0123_4567, 8, 32'h1234, 9, 32'h5678, 32'h0, 1, 0, 0, 1, 1,
               0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive_fwd(8, 32'hAAAA, 1, 8, 32'hBBBB, 1);
    #1;
`ifdef FWD_PATH_EN
    check("prio.m_wins", e_alu_a, 32'hAAAA);
`else
    check("prio.m_wins", e_alu_a, 32'h1234);
`endif
    drive_fwd(8, 32'hAAAA, 0, 8, 32'hBBBB, 1);
    #1;
`ifdef FWD_PATH_EN
    check("prio.w_only", e_alu_a, 32'hBBBB);
`else
    check("prio.w_only", e_alu_a, 32'h1234);
`endif
    drive_fwd(0, 32'h0, 0, 9, 32'hCCCC, 1);
    #1;
`ifdef FWD_PATH_EN
    check("prio.rt_w", e_store_data, 32'hCCCC);
`else
    check("prio.rt_w", e_store_data, 32'h5678);
`endif
    check("prio.rs_nohit", e_alu_a, 32'h1234);

    // $0 never takes a forwarded value.
    @(negedge clk);
    drive_fwd(0, 32'h0, 0, 0, 32'h0, 0);
    drive_d(mk(0, 0, 32'h3104, 32'h0, 3, 32'h9, 0, 32'h0, 32'h0, 2, 0, 0, 1, 0,
               0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive_fwd(0, 32'hFFFF, 1, 0, 32'hEEEE, 1);
    #1;
    check("zero.store", e_store_data, 32'h0);
    check("zero.alu_b", e_alu_b, 32'h0);
    check("zero.alu_a", e_alu_a, 32'h9);
    drive_fwd(0, 32'h0, 0, 0, 32'h0, 0);

    // Reset between edges discards the in-flight instruction at once.
    @(negedge clk);
    drive_d(vt[6]);
    @(posedge clk);
    #1;
    check("pre_reset.valid", {31'b0, e_valid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_nop("async_reset", EXP_RESET_PC);
    @(posedge clk);
    #1;
    check_nop("held_reset", EXP_RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("resume.valid", {31'b0, e_valid}, 32'h1);
    check("resume.pc", e_pc, 32'h3018);
    check("resume.tnext", {30'b0, m_tnew_next}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter TNEW_W, default 2, width of the Tnew field.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word held while a bubble occupies E.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bubble  input  1  hazard-unit stall; load a NOP into E this edge.
REQ-006 SHALL have port flush  input  1  squash; load a NOP into E this edge.
REQ-007 SHALL have ports d_pc, d_instr, d_rs_val, d_rt_val, d_ext_imm  input  32 each  D-stage payload.
REQ-008 SHALL have ports d_rs_addr, d_rt_addr, d_wr_addr  input  5 each  source and destination GPR numbers.
REQ-009 SHALL have ports d_alu_op (2), d_alu_src (1), d_reg_we (1), d_tnew (TNEW_W)  input  D-stage decoded control.
REQ-010 SHALL have ports m_fwd_addr (5), m_fwd_data (32), m_fwd_we (1), w_fwd_addr (5), w_fwd_data (32), w_fwd_we (1)  input  forwarding sources.
REQ-011 SHALL have ports e_alu_a, e_alu_b, e_store_data  output  32 each  ALU operands and forwarded rt value for memory stage.
REQ-012 SHALL have ports e_pc, e_instr (32), e_alu_op (2), e_rs_addr, e_rt_addr, e_wr_addr (5), e_reg_we (1), e_valid (1), e_tnew (TNEW_W), m_tnew_next (TNEW_W)  output  registered E-stage state.

Function
REQ-013 SHALL, on each rising edge with bubble=0 and flush=0, capture all d_* inputs into E registers and set e_valid=1.
REQ-014 SHALL, on a rising edge with bubble=1 or flush=1, load NOP: e_instr=NOP_INSTR, e_reg_we=0, e_wr_addr=0, e_tnew=0, e_alu_op=0, e_valid=0, other payload zero; e_pc SHALL keep the captured d_pc (exception-PC reporting).
REQ-015 SHALL treat bubble and flush asserted together identically to either alone.
REQ-016 SHALL have latency exactly one cycle from D inputs to E outputs; there is no hold/enable path (E never freezes).
REQ-017 SHALL compute forwarded rs as: m_fwd_data if m_fwd_we and m_fwd_addr==e_rs_addr and e_rs_addr!=0; else w_fwd_data if same test on W; else registered rs value; identically for rt.
REQ-018 SHALL give M priority over W when both match the same register.
REQ-019 SHALL never forward into register 0; operand for $0 is always 32'h0.
REQ-020 SHALL drive e_alu_a = forwarded rs; e_alu_b = registered ext_imm if alu_src=1, else forwarded rt; e_store_data = forwarded rt always.
REQ-021 SHALL drive m_tnew_next = e_tnew-1 saturating at 0 (0 stays 0).
REQ-022 Forwarding and m_tnew_next SHALL be purely combinational from E registers and *_fwd inputs.

Reset
REQ-023 SHALL, while reset=1, asynchronously force every E register to the NOP state of REQ-014 with e_pc=32'h0000_3000.
REQ-024 SHALL resume capture on the first rising edge after reset deasserts; reset mid-stream discards the in-flight instruction.

Configuration
REQ-025 With FWD_PATH_EN defined, SHALL implement REQ-017..REQ-019 forwarding.
REQ-026 Without FWD_PATH_EN, SHALL bypass forwarding: operands are the registered rs/rt values (rt still gated by alu_src); m_fwd_*/w_fwd_* inputs remain as ports, ignored.

Structure
REQ-027 Shared package SHALL hold ALU-op encodings (ADD=0, SUB=1, OR=2), NOP_INSTR, reset PC 32'h0000_3000, TNEW_W.
REQ-028 Forwarding selection SHALL be one sub-module fwd_mux instantiated twice (rs, rt).

Verification
REQ-029 Capture: d_rs_val=5, d_rt_val=7, alu_src=0, no fwd hits -> next cycle e_alu_a=5, e_alu_b=7, e_valid=1.
REQ-030 Priority: e_rs_addr=8, M and W both write r8 with 0xAAAA/0xBBBB -> e_alu_a=0xAAAA; drop m_fwd_we -> 0xBBBB.
REQ-031 Zero reg: e_rt_addr=0, m_fwd_addr=0, m_fwd_we=1, data 0xFFFF -> e_store_data=0 (and e_alu_b=0 when alu_src=0).
REQ-032 Bubble: bubble=1 with d_reg_we=1, d_tnew=2 -> e_reg_we=0, e_tnew=0, e_valid=0, e_instr=NOP_INSTR; m_tnew_next=0.
REQ-033 Tnew: d_tnew=2 captured -> e_tnew=2, m_tnew_next=1; d_tnew=0 -> m_tnew_next=0.
REQ-034 Reset: assert reset between edges -> outputs NOP immediately, e_pc=0x3000; build without FWD_PATH_EN -> REQ-030 yields registered rs value.
